// File: rtl/display_timing_gen_pkg.sv
// Shared timing arithmetic and pixel type for the panel timing generator,
// the frame-buffer reader and the bench-side display model.
package display_timing_gen_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam pixel_t PIXEL_BLANK = '0;

  // Full span of one axis: sync pulse + back porch + active area + front porch.
  function automatic int totalSpan(input int pulse, input int back, input int area,
                                   input int front);
    return pulse + back + area + front;
  endfunction

  function automatic int activeStart(input int pulse, input int back);
    return pulse + back;
  endfunction

  function automatic int activeEnd(input int pulse, input int back, input int area);
    return pulse + back + area;
  endfunction

endpackage

// File: rtl/display_pixel_fifo.sv
// Synchronous first-word-fall-through pixel FIFO; the head entry is visible on
// oDATA whenever oEMPTY is low. Depth must be a power of two.
module display_pixel_fifo
  import display_timing_gen_pkg::*;
#(
  parameter int P_DEPTH = 16
) (
  input  logic   iCLOCK,
  input  logic   iRESET,
  input  logic   iPUSH,
  input  pixel_t iDATA,
  input  logic   iPOP,
  output pixel_t oDATA,
  output logic   oFULL,
  output logic   oEMPTY
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(P_DEPTH);

  pixel_t        mem [P_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          doPush;
  logic          doPop;

  // Requests against a full/empty FIFO are dropped here so callers cannot corrupt pointers.
  assign doPush = iPUSH && !oFULL;
  assign doPop  = iPOP && !oEMPTY;

  assign oFULL  = (count == COUNT_FULL);
  assign oEMPTY = (count == '0);
  assign oDATA  = mem[rdPtr];

  always_ff @(posedge iCLOCK) begin
    if (doPush) begin
      mem[wrPtr] <= iDATA;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/display_timing_gen.sv
// Panel-side display timing: H/V counters, sync/active decode registered to the
// pins, and a pixel FIFO drained one entry per active clock.
module display_timing_gen
  import display_timing_gen_pkg::*;
#(
  parameter int P_H_AREA     = 640,
  parameter int P_V_AREA     = 480,
  parameter int P_THP        = 95,
  parameter int P_THB        = 48,
  parameter int P_THF        = 15,
  parameter int P_TVP        = 2,
  parameter int P_TVB        = 33,
  parameter int P_TVF        = 10,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic       iCLOCK,
  input  logic       iRESET,
  input  logic       iDISP_ENA,
  input  logic       iERR_CLEAR,
  input  logic       iPIXEL_VALID,
  output logic       oPIXEL_READY,
  input  logic [7:0] iPIXEL_R,
  input  logic [7:0] iPIXEL_G,
  input  logic [7:0] iPIXEL_B,
  output logic       onDISP_SYNC_H,
  output logic       onDISP_SYNC_V,
  output logic [7:0] oDISP_R,
  output logic [7:0] oDISP_G,
  output logic [7:0] oDISP_B,
  output logic       oFRAME_START,
  output logic       oERR_UNDERFLOW
);

  localparam int H_TOTAL = totalSpan(P_THP, P_THB, P_H_AREA, P_THF);
  localparam int V_TOTAL = totalSpan(P_TVP, P_TVB, P_V_AREA, P_TVF);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(P_THP);
  localparam logic [HW-1:0] H_ACT_START = HW'(activeStart(P_THP, P_THB));
  localparam logic [HW-1:0] H_ACT_END   = HW'(activeEnd(P_THP, P_THB, P_H_AREA));
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(P_TVP);
  localparam logic [VW-1:0] V_ACT_START = VW'(activeStart(P_TVP, P_TVB));
  localparam logic [VW-1:0] V_ACT_END   = VW'(activeEnd(P_TVP, P_TVB, P_V_AREA));

  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          hWrap;
  logic          vWrap;

  assign hWrap = (hCnt == H_LAST);
  assign vWrap = (vCnt == V_LAST);

  // Disabling holds both counters at zero so a re-enable always starts a fresh frame.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (!iDISP_ENA) begin
      hCnt <= '0;
      vCnt <= '0;
    end else begin
      hCnt <= hWrap ? '0 : hCnt + HW'(1);
      if (hWrap) begin
        vCnt <= vWrap ? '0 : vCnt + VW'(1);
      end
    end
  end

  logic hSyncDue;
  logic vSyncDue;
  logic hInWin;
  logic vInWin;
  logic activeDue;
  logic frameDue;

  assign hSyncDue  = iDISP_ENA && (hCnt < H_SYNC_END);
  assign vSyncDue  = iDISP_ENA && (vCnt < V_SYNC_END);
  assign hInWin    = (hCnt >= H_ACT_START) && (hCnt < H_ACT_END);
  assign vInWin    = (vCnt >= V_ACT_START) && (vCnt < V_ACT_END);
  assign activeDue = iDISP_ENA && hInWin && vInWin;
  assign frameDue  = iDISP_ENA && (hCnt == '0) && (vCnt == '0);

  // Upstream handshake: a pixel transfers on any clock where iPIXEL_VALID and
  // oPIXEL_READY are both high; ready is !full from the registered count, so a
  // full FIFO refuses a push even when the same clock pops.
  pixel_t pushData;
  pixel_t fifoHead;
  logic   fifoFull;
  logic   fifoEmpty;
  logic   push;
  logic   pop;
  logic   underflow;

  assign pushData     = '{r: iPIXEL_R, g: iPIXEL_G, b: iPIXEL_B};
  assign oPIXEL_READY = !fifoFull;
  assign push         = iPIXEL_VALID && !fifoFull;
  assign pop          = activeDue && !fifoEmpty;
  assign underflow    = activeDue && fifoEmpty;

  display_pixel_fifo #(
    .P_DEPTH(P_FIFO_DEPTH)
  ) u_fifo (
    .iCLOCK(iCLOCK),
    .iRESET(iRESET),
    .iPUSH (push),
    .iDATA (pushData),
    .iPOP  (pop),
    .oDATA (fifoHead),
    .oFULL (fifoFull),
    .oEMPTY(fifoEmpty)
  );

  // A starved active slot is still spent as black; the raster never slips.
  pixel_t pixOut;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      onDISP_SYNC_H  <= 1'b1;
      onDISP_SYNC_V  <= 1'b1;
      pixOut         <= PIXEL_BLANK;
      oFRAME_START   <= 1'b0;
      oERR_UNDERFLOW <= 1'b0;
    end else begin
      onDISP_SYNC_H <= !hSyncDue;
      onDISP_SYNC_V <= !vSyncDue;
      pixOut        <= pop ? fifoHead : PIXEL_BLANK;
      oFRAME_START  <= frameDue;
      if (underflow) begin
        oERR_UNDERFLOW <= 1'b1;
      end else if (iERR_CLEAR) begin
        oERR_UNDERFLOW <= 1'b0;
      end
    end
  end

  assign oDISP_R = pixOut.r;
  assign oDISP_G = pixOut.g;
  assign oDISP_B = pixOut.b;

endmodule
